// File: rtl/dm_store_unit.sv
// dm_store_unit
//   Data-memory write side of the M stage. Decodes SW/SB/SH stores into byte
//   enables, replicates store data onto the byte lanes, and merges the selected
//   lanes into a word-addressed RAM one cycle later. The raw word at the
//   current address is returned combinationally for the load extender.
//   After reset the RAM is zeroed one word per cycle while busy is held high.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous active-high reset
//   we        in   1   store request valid
//   storeop   in   2   00 SW, 01 SB, 10 SH, 11 no store
//   addr      in   32  byte address of the access
//   wdata     in   32  store data (SB uses [7:0], SH uses [15:0])
//   pc        in   32  PC of the storing instruction (write log only)
//   rdata     out  32  raw word at addr index, 0 while busy
//   byteen    out  4   byte lanes written this cycle
//   misalign  out  1   misaligned store request
//   busy      out  1   clear sequence in progress
module dm_store_unit #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  storeop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic        misalign,
  output logic        busy
);

  localparam logic [1:0] OP_SW   = 2'b00;
  localparam logic [1:0] OP_SB   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] clr_idx_r;
  logic [ADDR_W-1:0] clr_next_s;

  logic [31:0]       mem_r [DEPTH];

  logic [ADDR_W-1:0] index_s;
  logic              busy_s;
  logic              req_s;
  logic              misalign_s;
  logic [3:0]        byteen_s;
  logic [31:0]       lane_s;
  logic [31:0]       old_s;
  logic [31:0]       merged_s;

  // Upper address bits are dropped so the word index wraps modulo DEPTH.
  assign index_s = addr[ADDR_W+1:2];
  assign busy_s  = (state_r == CLEAR);
  assign old_s   = mem_r[index_s];

  // State and clear-index registers; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR;
      clr_idx_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      clr_idx_r <= clr_next_s;
    end
  end

  // Next-state logic: walk the clear index and drop to IDLE after the last word.
  always_comb begin
    state_next_s = state_r;
    clr_next_s   = clr_idx_r;
    case (state_r)
      IDLE: begin
        state_next_s = IDLE;
        clr_next_s   = clr_idx_r;
      end
      CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          state_next_s = IDLE;
          clr_next_s   = {ADDR_W{1'b0}};
        end else begin
          state_next_s = CLEAR;
          clr_next_s   = clr_idx_r + IDX_ONE;
        end
      end
      default: begin
        state_next_s = CLEAR;
        clr_next_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Store decode: gating, misalignment, lane replication and byte enables.
  always_comb begin
    req_s      = we & ~busy_s & (storeop != OP_NONE);
    misalign_s = 1'b0;
    lane_s     = wdata;
    byteen_s   = 4'b0000;
    case (storeop)
      OP_SW: begin
        lane_s     = wdata;
        misalign_s = req_s & (addr[1:0] != 2'b00);
      end
      OP_SB: begin
        lane_s     = {4{wdata[7:0]}};
        misalign_s = 1'b0;
      end
      OP_SH: begin
        lane_s     = {2{wdata[15:0]}};
        misalign_s = req_s & addr[0];
      end
      default: begin
        lane_s     = wdata;
        misalign_s = 1'b0;
      end
    endcase
    if (req_s & ~misalign_s) begin
      case (storeop)
        OP_SW:   byteen_s = 4'b1111;
        OP_SB:   byteen_s = 4'b0001 << addr[1:0];
        OP_SH:   byteen_s = addr[1] ? 4'b1100 : 4'b0011;
        default: byteen_s = 4'b0000;
      endcase
    end else begin
      byteen_s = 4'b0000;
    end
  end

  // Byte-lane merge of the replicated store data over the current word.
  always_comb begin
    merged_s = old_s;
    for (int i = 0; i < 4; i++) begin
      if (byteen_s[i]) begin
        merged_s[8*i +: 8] = lane_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = old_s[8*i +: 8];
      end
    end
  end

  // RAM write port: reset and the clear sequence take priority over stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[{ADDR_W{1'b0}}] <= 32'h0000_0000;
    end else if (state_r == CLEAR) begin
      mem_r[clr_idx_r] <= 32'h0000_0000;
    end else if (byteen_s != 4'b0000) begin
      mem_r[index_s] <= merged_s;
    end
  end

  // Simulation write log: one line per committed store.
  always_ff @(posedge clk) begin
    if (!reset && (byteen_s != 4'b0000)) begin
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_s);
    end
  end

  assign rdata    = busy_s ? 32'h0000_0000 : old_s;
  assign byteen   = byteen_s;
  assign misalign = misalign_s;
  assign busy     = busy_s;

endmodule

// File: tb/tb_dm_store_unit.sv
// tb_dm_store_unit
//   Directed bench for dm_store_unit with a 16-word RAM. A byte-level memory
//   model predicts every output each cycle; literal expectations pin the model.
module tb_dm_store_unit;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  storeop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic [3:0]  byteen;
  logic        misalign;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: word contents and number of clear cycles still outstanding.
  logic [31:0] m_mem [DEPTH];
  int          m_left = 0;

  dm_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .we(we), .storeop(storeop), .addr(addr),
    .wdata(wdata), .pc(pc), .rdata(rdata), .byteen(byteen),
    .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_busy();
    return m_left > 0;
  endfunction

  function automatic bit m_req();
    return we && !m_busy() && (storeop != 2'd3);
  endfunction

  function automatic bit m_mis();
    return m_req() && ((storeop == 2'd0 && (addr % 4) != 0) ||
                       (storeop == 2'd2 && (addr % 2) != 0));
  endfunction

  function automatic logic [3:0] m_be();
    int off;
    off = int'(addr % 4);
    if (!m_req() || m_mis()) return 4'd0;
    case (storeop)
      2'd0:    return 4'd15;
      2'd1:    return 4'(1 << off);
      2'd2:    return (off >= 2) ? 4'd12 : 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  function automatic int m_idx();
    return int'((addr >> 2) % DEPTH);
  endfunction

  // Model update at each rising edge.
  always @(posedge clk) begin
    logic [3:0] be;
    int         idx;
    be  = m_be();
    idx = m_idx();
    if (reset) begin
      m_left = DEPTH;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          case (storeop)
            2'd0:    m_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            2'd1:    m_mem[idx][8*k +: 8] = wdata[7:0];
            default: m_mem[idx][8*k +: 8] = wdata[8*(k%2) +: 8];
          endcase
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", {31'd0, busy}, {31'd0, m_busy()});
      chk("m_misalign", {31'd0, misalign}, {31'd0, m_mis()});
      chk("m_byteen", {28'd0, byteen}, {28'd0, m_be()});
      chk("m_rdata", rdata, m_busy() ? 32'd0 : m_mem[m_idx()]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    we      = w;
    storeop = op;
    addr    = a;
    wdata   = d;
    pc      = pc + 32'd4;
  endtask

  // Count busy cycles from now (reset already low), bounded.
  task automatic count_busy(input string name, input bit store_first);
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (c == 0 && store_first) chk("busy_store_byteen", {28'd0, byteen}, 32'd0);
      if (!busy) break;
      n++;
      step();
    end
    drive(1'b0, 2'b11, 32'd0, 32'd0);
    chk(name, n, 32'd16);
  endtask

  task automatic store_be(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be);
    drive(1'b1, op, a, d);
    #2;
    chk(name, {28'd0, byteen}, {28'd0, exp_be});
    step();
  endtask

  task automatic read_word(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 2'b11, a, 32'd0);
    #2;
    chk(name, rdata, exp);
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    pc = 32'h0000_1000;
    drive(1'b0, 2'b11, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Clear after reset, with a store attempt while busy.
    drive(1'b1, 2'b00, 32'h8, 32'hDEAD_BEEF);
    count_busy("clear_len", 1'b1);
    for (int i = 0; i < DEPTH; i++) read_word("zero_word", 32'(i * 4), 32'd0);

    // Word, byte and halfword stores.
    store_be("sw_be", 2'b00, 32'h8, 32'h1234_5678, 4'b1111);
    read_word("sw_word", 32'h8, 32'h1234_5678);
    store_be("sb_be", 2'b01, 32'hA, 32'hFFFF_FFAB, 4'b0100);
    read_word("sb_word", 32'h8, 32'h12AB_5678);
    store_be("sh_hi_be", 2'b10, 32'hE, 32'h0000_BEEF, 4'b1100);
    read_word("sh_hi_word", 32'hC, 32'hBEEF_0000);
    store_be("sh_lo_be", 2'b10, 32'hC, 32'hFFFF_1234, 4'b0011);
    read_word("sh_lo_word", 32'hC, 32'hBEEF_1234);
    store_be("sb_l3_be", 2'b01, 32'h13, 32'h0000_005A, 4'b1000);
    read_word("sb_l3_word", 32'h10, 32'h5A00_0000);
    read_word("wrap_read", 32'h48, 32'h12AB_5678);

    // Read of a word being written shows the old value.
    drive(1'b1, 2'b00, 32'h14, 32'hCAFE_F00D);
    #2;
    chk("rw_same_old", rdata, 32'd0);
    step();
    read_word("rw_same_new", 32'h14, 32'hCAFE_F00D);

    // Misaligned and no-op requests write nothing.
    drive(1'b1, 2'b00, 32'h6, 32'hFFFF_FFFF);
    #2;
    chk("sw_mis", {31'd0, misalign}, 32'd1);
    chk("sw_mis_be", {28'd0, byteen}, 32'd0);
    step();
    drive(1'b1, 2'b10, 32'h5, 32'hFFFF_FFFF);
    #2;
    chk("sh_mis", {31'd0, misalign}, 32'd1);
    chk("sh_mis_be", {28'd0, byteen}, 32'd0);
    step();
    store_be("nop_be", 2'b11, 32'h4, 32'hFFFF_FFFF, 4'b0000);
    read_word("mis_unchanged", 32'h4, 32'd0);

    // Reset mid-clear restarts the full clear; then a wrapped store.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("reclear_len", 1'b0);
    store_be("wrap_sw_be", 2'b00, 32'h40, 32'hA5A5_A5A5, 4'b1111);
    read_word("wrap_word0", 32'h0, 32'hA5A5_A5A5);
    read_word("cleared_word", 32'h8, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
